// File: rtl/interface_tx_bridge.sv
// interface_tx_bridge
// Bridges a bus slave's parallel byte port to a UART-style serial line.
// Bytes written by the slave are queued in a small FIFO and sent as
// start bit, DATA_WIDTH data bits (LSB first), optional parity and a stop bit.
// The slave may read back the most recently popped byte via rd_req/dv.
//
// Optional feature: define IFACE_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
//
// Ports:
//   clk       - sole clock, all logic on posedge
//   rstn      - synchronous active-low reset
//   wr_en     - one-cycle write strobe, din is queued if FIFO not full
//   din       - byte to queue
//   rd_req    - request for the last popped byte
//   dout      - last byte popped for transmission
//   dv        - one-cycle valid pulse, one cycle after rd_req
//   uart_tx   - serial output, idle high
//   fifo_full - FIFO holds 2**FIFO_AW entries
//   overflow  - sticky, a write was dropped while full
//   busy      - frame in progress or FIFO non-empty
//   tx_count  - completed frames, wraps at 256
module interface_tx_bridge #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dv,
    output logic                  uart_tx,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  busy,
    output logic [7:0]            tx_count
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   ZERO_COUNT = {(FIFO_AW + 1){1'b0}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef IFACE_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [FIFO_AW-1:0]    head_r;
    logic [FIFO_AW-1:0]    tail_r;
    logic [FIFO_AW:0]      count_r;
    logic [BAUD_W-1:0]     baud_r;
    logic [BIT_W-1:0]      bit_idx_r;
    logic [DATA_WIDTH-1:0] shift_r;
`ifdef IFACE_PARITY_EN
    logic                  parity_r;
`endif

    logic push_s;
    logic pop_s;

    // Full is judged on the count at cycle start, so a same-cycle pop never rescues a write.
    assign fifo_full = (count_r == FULL_COUNT);
    assign push_s    = wr_en && !fifo_full;
    assign pop_s     = (state_r == IDLE) && (count_r != ZERO_COUNT);
    assign busy      = (state_r != IDLE) || (count_r != ZERO_COUNT);

    // FIFO storage array, written at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (rstn && push_s) begin
            mem_r[tail_r] <= din;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_r   <= {FIFO_AW{1'b0}};
            tail_r   <= {FIFO_AW{1'b0}};
            count_r  <= ZERO_COUNT;
            overflow <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + FIFO_AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (FIFO_AW + 1)'(1);
                2'b01:   count_r <= count_r - (FIFO_AW + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmit FSM; uart_tx is loaded one edge ahead so it changes with the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= {BIT_W{1'b0}};
            shift_r   <= {DATA_WIDTH{1'b0}};
            uart_tx   <= 1'b1;
            dout      <= {DATA_WIDTH{1'b0}};
            dv        <= 1'b0;
            tx_count  <= 8'd0;
`ifdef IFACE_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            dv <= rd_req;
            case (state_r)
                IDLE: begin
                    baud_r    <= {BAUD_W{1'b0}};
                    bit_idx_r <= {BIT_W{1'b0}};
                    if (pop_s) begin
                        shift_r <= mem_r[head_r];
                        dout    <= mem_r[head_r];
                        uart_tx <= 1'b0;
                        state_r <= START;
`ifdef IFACE_PARITY_EN
                        parity_r <= ^mem_r[head_r];
`endif
                    end else begin
                        uart_tx <= 1'b1;
                    end
                end
                START: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        uart_tx <= shift_r[0];
                        state_r <= DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r <= {BAUD_W{1'b0}};
                        if (bit_idx_r == BIT_LAST) begin
                            bit_idx_r <= {BIT_W{1'b0}};
`ifdef IFACE_PARITY_EN
                            uart_tx <= parity_r;
                            state_r <= PARITY;
`else
                            uart_tx <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            // shift_r[0] is the bit on the line; expose the next one.
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                            shift_r   <= shift_r >> 1;
                            uart_tx   <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
`ifdef IFACE_PARITY_EN
                PARITY: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        uart_tx <= 1'b1;
                        state_r <= STOP;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r   <= {BAUD_W{1'b0}};
                        tx_count <= tx_count + 8'd1;
                        state_r  <= IDLE;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                    uart_tx <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interface_tx_bridge.sv
// Self-checking bench for interface_tx_bridge (CLKS_PER_BIT=4, FIFO_AW=2).
// A frame-level reference model (byte queue plus position inside the current
// frame) predicts every output each cycle; stimulus mixes directed scenarios
// with randomized writes, reads and resets.
module tb_interface_tx_bridge;

    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int AW   = 2;
    localparam int DEPTH = 1 << AW;
`ifdef IFACE_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FLEN = NBITS * CPB;

    logic          clk;
    logic          rstn;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_req;
    logic [DW-1:0] dout;
    logic          dv;
    logic          uart_tx;
    logic          fifo_full;
    logic          overflow;
    logic          busy;
    logic [7:0]    tx_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [DW-1:0] m_q[$];
    logic          m_ovf;
    logic [DW-1:0] m_dout;
    logic          m_dv;
    int            m_txc;
    bit            m_in_frame;
    int            m_pos;
    logic [DW-1:0] m_cur;

    interface_tx_bridge #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .din      (din),
        .rd_req   (rd_req),
        .dout     (dout),
        .dv       (dv),
        .uart_tx  (uart_tx),
        .fifo_full(fifo_full),
        .overflow (overflow),
        .busy     (busy),
        .tx_count (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    // Line level for bit slot idx of a frame carrying byte b.
    function automatic logic frame_bit(input logic [DW-1:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return b[idx-1];
`ifdef IFACE_PARITY_EN
        if (idx == DW + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit rst);
        int  occ;
        bit  do_pop;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0; m_dout = '0; m_dv = 1'b0; m_txc = 0;
            m_in_frame = 1'b0; m_pos = 0;
            return;
        end
        occ    = m_q.size();
        m_dv   = rd;
        do_pop = !m_in_frame && (occ > 0);
        if (m_in_frame) begin
            m_pos++;
            if (m_pos == FLEN) begin
                m_in_frame = 1'b0;
                m_txc = (m_txc + 1) % 256;
            end
        end
        if (do_pop) begin
            m_cur = m_q.pop_front();
            m_dout = m_cur;
            m_in_frame = 1'b1;
            m_pos = 0;
        end
        if (wr) begin
            if (occ == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        logic exp_tx;
        exp_tx = m_in_frame ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
        check("uart_tx", 32'(uart_tx), 32'(exp_tx));
        check("busy", 32'(busy), 32'(m_in_frame || (m_q.size() > 0)));
        check("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("tx_count", 32'(tx_count), 32'(m_txc));
        check("dv", 32'(dv), 32'(m_dv));
        check("dout", 32'(dout), 32'(m_dout));
    endtask

    task automatic tick(input bit wr, input logic [DW-1:0] d, input bit rd, input bit rst);
        @(negedge clk);
        wr_en  = wr;
        din    = d;
        rd_req = rd;
        rstn   = !rst;
        @(posedge clk);
        model_step(wr, d, rd, rst);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        wr_en = 1'b0; din = 8'h00; rd_req = 1'b0; rstn = 1'b0;
        m_in_frame = 1'b0; m_pos = 0; m_cur = '0;
        m_ovf = 1'b0; m_dout = '0; m_dv = 1'b0; m_txc = 0;

        // reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        // single byte 0xA5
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(FLEN + 4);
        check("a5_tx_count", 32'(tx_count), 32'd1);

        // rd_req after reset before any write returns 0
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("rd_empty_dout", 32'(dout), 32'h00);

        // write 0x3C, read after pop
        tick(1'b1, 8'h3C, 1'b0, 1'b0);
        idle(2);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_3c_dout", 32'(dout), 32'h3C);
        idle(FLEN);

        // burst of 6 writes: one popped, four stored, one dropped
        for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("burst_overflow", 32'(overflow), 32'd1);
        idle(5 * (FLEN + 1) + 4);
        check("burst_busy_done", 32'(busy), 32'd0);

        // reset mid-frame during data bit 3, then a normal frame
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(1 + CPB + 3 * CPB + 1);
        tick(1'b1, 8'hFF, 1'b1, 1'b1);
        check("midrst_tx_count", 32'(tx_count), 32'd0);
        tick(1'b1, 8'h07, 1'b0, 1'b0);
        idle(FLEN + 4);
        tick(1'b1, 8'h03, 1'b0, 1'b0);
        idle(FLEN + 4);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 799) == 0));
        end
        for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(5 * (FLEN + 1) + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
